// File: rtl/mnist_pkg.sv
// Shared sizing and state encoding for the classifier output stage.
package mnist_pkg;

  localparam int NUM_CLASS = 10;
  localparam int DATA_W    = 32;
  localparam int BIAS_W    = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_unit_if.sv
// Frame-in / result-out bundle for argmax_unit; master drives frames, slave returns results.
interface argmax_unit_if #(
  parameter int NUM_CLASS = mnist_pkg::NUM_CLASS,
  parameter int DATA_W    = mnist_pkg::DATA_W,
  parameter int BIAS_W    = mnist_pkg::BIAS_W,
  parameter int IDX_W     = mnist_pkg::IDX_W
);
  logic                          valid;
  logic [NUM_CLASS*DATA_W-1:0]   data;
  logic [NUM_CLASS*BIAS_W-1:0]   bias;
  logic                          ready;
  logic                          done;
  logic [IDX_W-1:0]              class_idx;
  logic signed [DATA_W:0]        score;
  logic                          drop;

  modport master (
    output valid, data, bias,
    input  ready, done, class_idx, score, drop
  );

  modport slave (
    input  valid, data, bias,
    output ready, done, class_idx, score, drop
  );
endinterface

// File: rtl/argmax_unit.sv
// Sequential biased argmax: one class per cycle through a single shared adder and comparator.
// Result after NUM_CLASS scan cycles plus a one-cycle DONE; frames offered mid-scan are dropped.
module argmax_unit #(
  parameter int NUM_CLASS = mnist_pkg::NUM_CLASS,
  parameter int DATA_W    = mnist_pkg::DATA_W,
  parameter int BIAS_W    = mnist_pkg::BIAS_W,
  parameter int IDX_W     = mnist_pkg::IDX_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  input  logic [NUM_CLASS*DATA_W-1:0] data_i,
  input  logic [NUM_CLASS*BIAS_W-1:0] bias_i,
  output logic                        ready_o,
  output logic                        done_o,
  output logic [IDX_W-1:0]            class_o,
  output logic signed [DATA_W:0]      score_o,
  output logic                        drop_o
);
  import mnist_pkg::*;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              k_q, k_d;
  logic signed [DATA_W:0]        best_q, best_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_CLASS*DATA_W-1:0]   data_q, data_d;
  logic [NUM_CLASS*BIAS_W-1:0]   bias_q, bias_d;
  logic [IDX_W-1:0]              class_q, class_d;
  logic signed [DATA_W:0]        score_q, score_d;

  logic [DATA_W-1:0]             score_k;
  logic [BIAS_W-1:0]             bias_k;
  logic signed [DATA_W:0]        sum_k;
  logic                          take_k;
  logic                          last_k;
  logic                          accept;

  // Shared datapath: both operands widened by one bit so the sum can never wrap.
  always_comb begin
    score_k = data_q[k_q*DATA_W +: DATA_W];
    bias_k  = bias_q[k_q*BIAS_W +: BIAS_W];
    sum_k   = $signed({score_k[DATA_W-1], score_k})
            + $signed({{(DATA_W+1-BIAS_W){bias_k[BIAS_W-1]}}, bias_k});
    take_k  = (k_q == '0) || (sum_k > best_q);
    last_k  = (k_q == IDX_W'(NUM_CLASS-1));
    accept  = valid_i && (state_q != ST_SCAN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      bias_q  <= '0;
      class_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      bias_q  <= bias_d;
      class_q <= class_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i) state_d = ST_SCAN;
      ST_SCAN: if (last_k)  state_d = ST_DONE;
      ST_DONE: state_d = valid_i ? ST_SCAN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    k_d     = k_q;
    best_d  = best_q;
    idx_d   = idx_q;
    data_d  = data_q;
    bias_d  = bias_q;
    class_d = class_q;
    score_d = score_q;

    if (accept) begin
      data_d = data_i;
      bias_d = bias_i;
      k_d    = '0;
    end else if (state_q == ST_SCAN) begin
      k_d = k_q + IDX_W'(1);
      if (take_k) begin
        best_d = sum_k;
        idx_d  = k_q;
      end
      // Publish the final class in the same cycle it is compared, so DONE sees the result.
      if (last_k) begin
        k_d     = '0;
        class_d = take_k ? k_q   : idx_q;
        score_d = take_k ? sum_k : best_q;
      end
    end
  end

  always_comb begin
    ready_o = (state_q != ST_SCAN);
    done_o  = (state_q == ST_DONE);
    drop_o  = valid_i && (state_q == ST_SCAN) && !rst_i;
    class_o = class_q;
    score_o = score_q;
  end

endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit: vector table of single frames plus busy, reset and back-to-back sequences.
module tb_argmax_unit;
  import mnist_pkg::*;

  localparam int NC = NUM_CLASS;
  localparam int DW = DATA_W;
  localparam int BW = BIAS_W;
  localparam int IW = IDX_W;
  localparam int NVEC = 7;

  typedef logic [NC*DW-1:0] dvec_t;
  typedef logic [NC*BW-1:0] bvec_t;

  typedef struct {
    string                name;
    dvec_t                data;
    bvec_t                bias;
    logic [IW-1:0]        cls;
    logic signed [DW:0]   score;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  argmax_unit_if #(.NUM_CLASS(NC), .DATA_W(DW), .BIAS_W(BW), .IDX_W(IW)) bus ();

  argmax_unit #(.NUM_CLASS(NC), .DATA_W(DW), .BIAS_W(BW), .IDX_W(IW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (bus.valid),
    .data_i  (bus.data),
    .bias_i  (bus.bias),
    .ready_o (bus.ready),
    .done_o  (bus.done),
    .class_o (bus.class_idx),
    .score_o (bus.score),
    .drop_o  (bus.drop)
  );

  int checks   = 0;
  int failures = 0;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Presents a frame in the current cycle; returns at the negedge after the accepting edge.
  task automatic launch(input dvec_t d, input bvec_t b);
    bus.valid = 1'b1;
    bus.data  = d;
    bus.bias  = b;
    @(negedge clk_i);
    bus.valid = 1'b0;
    bus.data  = ~d;
    bus.bias  = ~b;
  endtask

  // Counts rising edges from acceptance (inclusive) until done_o is seen, optionally
  // offering an intruding frame at a given edge count.
  task automatic wait_done(input int inject_at, output int edges, output int drops, output int busy_ready);
    edges      = 1;
    drops      = 0;
    busy_ready = 0;
    while (!bus.done && edges < 40) begin
      if (edges == inject_at) begin
        bus.valid = 1'b1;
        for (int k = 0; k < NC; k++) bus.data[k*DW +: DW] = DW'(5000);
      end
      @(negedge clk_i);
      edges++;
      if (bus.drop) drops++;
      if (bus.ready && !bus.done) busy_ready++;
      bus.valid = 1'b0;
    end
  endtask

  dvec_t asc_d;
  dvec_t neg_d;
  bvec_t zero_b;
  int    lat, drops, busy_ready, dones;

  initial begin
    for (int k = 0; k < NC; k++) begin
      asc_d[k*DW +: DW] = DW'(100*k);
      neg_d[k*DW +: DW] = (k == 3) ? DW'(-5) : DW'(-1000);
    end
    zero_b = '0;

    vecs[0] = '{"ascending", asc_d, zero_b, IW'(9), (DW+1)'(900)};
    vecs[1] = '{"ties", '0, zero_b, IW'(0), (DW+1)'(5)};
    for (int k = 0; k < NC; k++) vecs[1].data[k*DW +: DW] = DW'(5);
    vecs[2] = '{"negatives", neg_d, zero_b, IW'(3), -(DW+1)'(5)};
    vecs[3] = '{"bias_reorder", '0, zero_b, IW'(7), (DW+1)'(1010)};
    vecs[3].data[2*DW +: DW] = DW'(1000);
    vecs[3].data[7*DW +: DW] = DW'(990);
    vecs[3].bias[7*BW +: BW] = BW'(20);
    vecs[4] = '{"max_extreme", '0, zero_b, IW'(4), 33'sd2147516414};
    vecs[4].data[4*DW +: DW] = 32'h7FFF_FFFF;
    vecs[4].bias[4*BW +: BW] = 16'sd32767;
    vecs[5] = '{"min_extreme", '0, '0, IW'(6), -33'sd2147516415};
    for (int k = 0; k < NC; k++) begin
      vecs[5].data[k*DW +: DW] = 32'h8000_0000;
      vecs[5].bias[k*BW +: BW] = (k == 6) ? 16'h8001 : 16'h8000;
    end
    vecs[6] = '{"neg_bias_tie", '0, '0, IW'(1), -(DW+1)'(3)};
    for (int k = 0; k < NC; k++) vecs[6].bias[k*BW +: BW] = (k == 1 || k == 8) ? BW'(-3) : BW'(-7);

    // Reset, with a frame offered while reset is high that must not start a scan.
    rst_i     = 1'b1;
    bus.valid = 1'b0;
    bus.data  = '0;
    bus.bias  = '0;
    @(negedge clk_i);
    bus.valid = 1'b1;
    bus.data  = asc_d;
    @(negedge clk_i);
    rst_i     = 1'b0;
    bus.valid = 1'b0;
    check("reset_ready", bus.ready, 1);
    check("reset_done", bus.done, 0);
    check("reset_drop", bus.drop, 0);
    check("reset_class", bus.class_idx, 0);
    check("reset_score", bus.score, 0);
    @(negedge clk_i);
    check("valid_in_reset_ignored", bus.ready, 1);

    for (int i = 0; i < NVEC; i++) begin
      check({vecs[i].name, "_ready"}, bus.ready, 1);
      launch(vecs[i].data, vecs[i].bias);
      wait_done(-1, lat, drops, busy_ready);
      check({vecs[i].name, "_latency"}, lat, 11);
      check({vecs[i].name, "_class"}, bus.class_idx, vecs[i].cls);
      check({vecs[i].name, "_score"}, bus.score, vecs[i].score);
      check({vecs[i].name, "_busy_ready"}, busy_ready, 0);
      @(negedge clk_i);
      check({vecs[i].name, "_done_pulse"}, bus.done, 0);
      check({vecs[i].name, "_hold"}, bus.class_idx, vecs[i].cls);
    end

    // Intruding frame during scan cycle 3.
    launch(asc_d, zero_b);
    wait_done(3, lat, drops, busy_ready);
    check("busy_drops", drops, 1);
    check("busy_latency", lat, 11);
    check("busy_class", bus.class_idx, 9);
    check("busy_score", bus.score, 900);
    @(negedge clk_i);
    check("busy_done_pulse", bus.done, 0);

    // Back-to-back: second frame offered in the DONE cycle of the first.
    @(negedge clk_i);
    launch(vecs[3].data, vecs[3].bias);
    wait_done(-1, lat, drops, busy_ready);
    check("b2b_first_class", bus.class_idx, 7);
    check("b2b_ready_in_done", bus.ready, 1);
    launch(neg_d, zero_b);
    check("b2b_held_class", bus.class_idx, 7);
    check("b2b_held_score", bus.score, 1010);
    check("b2b_accepted", bus.ready, 0);
    wait_done(-1, lat, drops, busy_ready);
    check("b2b_latency", lat, 11);
    check("b2b_class", bus.class_idx, 3);
    check("b2b_score", bus.score, -(DW+1)'(5));

    // Reset during scan cycle 5 abandons the frame.
    @(negedge clk_i);
    launch(asc_d, zero_b);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_ready", bus.ready, 1);
    check("midrst_class", bus.class_idx, 0);
    check("midrst_score", bus.score, 0);
    dones = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle_ready", bus.ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
